// File: rtl/bit_scan_n_if.sv
// Handshake bundle for bit_scan_n: scan request in, stream of set-bit indices out.
interface bit_scan_n_if #(
  parameter int REGISTER_LENGTH = 64,
  parameter int IDX_W           = 6
);
  logic                       start_i;
  logic [REGISTER_LENGTH-1:0] word_i;
  logic                       busy_o;
  logic                       idx_valid_o;
  logic [IDX_W-1:0]           idx_o;
  logic                       idx_ready_i;
  logic                       last_o;
  logic                       done_o;
  logic [IDX_W:0]             count_o;

  modport master (
    output start_i, word_i, idx_ready_i,
    input  busy_o, idx_valid_o, idx_o, last_o, done_o, count_o
  );

  modport slave (
    input  start_i, word_i, idx_ready_i,
    output busy_o, idx_valid_o, idx_o, last_o, done_o, count_o
  );
endinterface

// File: rtl/bit_scan_n.sv
// Decomposes a word into the indices of its set bits, lowest first, over a
// valid/ready stream; one index per cycle when the consumer never stalls.
module bit_scan_n #(
  parameter int REGISTER_LENGTH = 64,
  parameter int IDX_W           = 6
) (
  input  logic        clk_i,
  input  logic        reset_i,
  bit_scan_n_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                 state;
  logic [REGISTER_LENGTH-1:0] pending;
  logic [REGISTER_LENGTH-1:0] pending_rest;
  logic [IDX_W:0]             count;
  logic [IDX_W-1:0]           lowest;
  logic                       scanning;

  // Clearing the lowest set bit also tells us whether it was the last one.
  assign pending_rest = pending & (pending - REGISTER_LENGTH'(1));
  assign scanning     = (state == SCAN);

  // NOTE: every always_comb output gets a default before the loop, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    lowest = '0;
    for (int i = REGISTER_LENGTH - 1; i >= 0; i--) begin
      if (pending[i]) lowest = IDX_W'(i);
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples the pre-edge values, matching the hardware it describes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      pending <= '0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            pending <= bus.word_i;
            count   <= '0;
            state   <= (bus.word_i != '0) ? SCAN : DONE;
          end
        end
        SCAN: begin
          if (bus.idx_ready_i) begin
            pending <= pending_rest;
            count   <= count + (IDX_W + 1)'(1);
            if (pending_rest == '0) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o      = (state != IDLE);
  assign bus.idx_valid_o = scanning;
  assign bus.idx_o       = scanning ? lowest : '0;
  assign bus.last_o      = scanning && (pending_rest == '0);
  assign bus.done_o      = (state == DONE);
  assign bus.count_o     = count;

endmodule

// File: tb/tb_bit_scan_n.sv
// Directed bench for bit_scan_n: a queue-based model checked every cycle,
// plus literal expectations for each scenario.
module tb_bit_scan_n;

  localparam int RL = 64;
  localparam int IW = 6;

  logic clk;
  logic reset;

  bit_scan_n_if #(.REGISTER_LENGTH(RL), .IDX_W(IW)) bus ();

  bit_scan_n #(.REGISTER_LENGTH(RL), .IDX_W(IW)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Observed transfers and done pulses, used by the literal checks.
  int log_idx[$];
  int log_last[$];
  int done_cnt;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the indices still owed for the current word, in ascending order.
  int q[$];
  bit m_done = 1'b0;
  int m_count = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy",      bus.busy_o,      (q.size() > 0) || m_done);
        check("idx_valid", bus.idx_valid_o, q.size() > 0);
        check("idx",       bus.idx_o,       (q.size() > 0) ? q[0] : 0);
        check("last",      bus.last_o,      q.size() == 1);
        check("done",      bus.done_o,      m_done);
        check("count",     bus.count_o,     m_count);

        if (!reset && bus.idx_valid_o && bus.idx_ready_i) begin
          log_idx.push_back(int'(bus.idx_o));
          log_last.push_back(int'(bus.last_o));
        end
        if (bus.done_o) done_cnt++;

        if (reset) begin
          q.delete();
          m_done  = 1'b0;
          m_count = 0;
        end else if (m_done) begin
          m_done = 1'b0;
        end else if (q.size() > 0) begin
          if (bus.idx_ready_i) begin
            void'(q.pop_front());
            m_count++;
            if (q.size() == 0) m_done = 1'b1;
          end
        end else if (bus.start_i) begin
          m_count = 0;
          for (int b = 0; b < RL; b++) if (bus.word_i[b]) q.push_back(b);
          if (q.size() == 0) m_done = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_idx.delete();
    log_last.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input logic [RL-1:0] w);
    bus.start_i = 1'b1;
    bus.word_i  = w;
    tick();
    bus.start_i = 1'b0;
    bus.word_i  = '0;
  endtask

  task automatic run_until_done(input int max, output int cycles);
    bit seen = 1'b0;
    cycles = 0;
    for (int i = 0; i < max; i++) begin
      if (bus.done_o) begin
        seen = 1'b1;
        tick();
        break;
      end
      tick();
      cycles++;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done_o within %0d cycles", max);
    end
  endtask

  initial begin
    int cyc;
    int bad;

    reset           = 1'b1;
    bus.start_i     = 1'b0;
    bus.word_i      = '0;
    bus.idx_ready_i = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;

    // Reset state
    check("rst_busy",  bus.busy_o, 0);
    check("rst_valid", bus.idx_valid_o, 0);
    check("rst_idx",   bus.idx_o, 0);
    check("rst_last",  bus.last_o, 0);
    check("rst_done",  bus.done_o, 0);
    check("rst_count", bus.count_o, 0);

    // Basic scan, start accepted on the first cycle after reset release
    reset = 1'b0;
    bus.idx_ready_i = 1'b1;
    clear_log();
    do_start(64'h0000_0000_0000_0112);
    check("basic_latency_valid", bus.idx_valid_o, 1);
    check("basic_latency_idx",   bus.idx_o, 1);
    run_until_done(20, cyc);
    check("basic_n",     log_idx.size(), 3);
    check("basic_idx0",  log_idx[0], 1);
    check("basic_idx1",  log_idx[1], 4);
    check("basic_idx2",  log_idx[2], 8);
    check("basic_last",  {log_last[0][0], log_last[1][0], log_last[2][0]}, 3'b001);
    check("basic_cycles", cyc, 3);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_count", bus.count_o, 3);

    // Zero word
    clear_log();
    do_start('0);
    check("zero_valid", bus.idx_valid_o, 0);
    check("zero_done",  bus.done_o, 1);
    check("zero_busy",  bus.busy_o, 1);
    tick();
    check("zero_done_after", bus.done_o, 0);
    check("zero_busy_after", bus.busy_o, 0);
    check("zero_count",      bus.count_o, 0);
    check("zero_done_cnt",   done_cnt, 1);

    // Backpressure: ready low for three SCAN cycles
    bus.idx_ready_i = 1'b0;
    clear_log();
    do_start(64'h8000_0000_0000_0001);
    tick();
    tick();
    check("bp_hold_idx",   bus.idx_o, 0);
    check("bp_hold_count", bus.count_o, 0);
    bus.idx_ready_i = 1'b1;
    tick();
    check("bp_second_idx",  bus.idx_o, 63);
    check("bp_second_last", bus.last_o, 1);
    run_until_done(10, cyc);
    check("bp_n",     log_idx.size(), 2);
    check("bp_idx0",  log_idx[0], 0);
    check("bp_idx1",  log_idx[1], 63);
    check("bp_count", bus.count_o, 2);

    // All ones, back-to-back
    clear_log();
    do_start('1);
    run_until_done(100, cyc);
    bad = 0;
    for (int k = 0; k < RL; k++) if (log_idx[k] != k) bad++;
    check("ones_n",        log_idx.size(), 64);
    check("ones_order",    bad, 0);
    check("ones_last",     log_last[63], 1);
    check("ones_cycles",   cyc, 64);
    check("ones_done_cnt", done_cnt, 1);
    check("ones_count",    bus.count_o, 64);

    // start_i while busy is ignored
    bus.idx_ready_i = 1'b0;
    clear_log();
    do_start(64'h3);
    do_start(64'hF0);
    bus.idx_ready_i = 1'b1;
    run_until_done(10, cyc);
    tick();
    check("busy_n",     log_idx.size(), 2);
    check("busy_idx0",  log_idx[0], 0);
    check("busy_idx1",  log_idx[1], 1);
    check("busy_count", bus.count_o, 2);
    check("busy_idle",  bus.busy_o, 0);

    // Reset mid-scan after the first transfer
    clear_log();
    do_start(64'h7);
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_valid", bus.idx_valid_o, 0);
    check("mid_rst_busy",  bus.busy_o, 0);
    check("mid_rst_count", bus.count_o, 0);
    reset = 1'b0;
    do_start(64'h4);
    check("mid_rst_no_done", done_cnt, 0);
    check("mid_rst_idx",     bus.idx_o, 2);
    run_until_done(10, cyc);
    check("mid_rst_n",        log_idx.size(), 2);
    check("mid_rst_log1",     log_idx[1], 2);
    check("mid_rst_done_cnt", done_cnt, 1);
    check("mid_rst_count2",   bus.count_o, 1);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1);
  end

endmodule

// File: doc/bit_scan_n.md
BIT_SCAN_N -- requirements
Module: bit_scan_n

Interface
REQ-001 The block SHALL have parameter REGISTER_LENGTH, default 64, which sets the width of the scanned word.
REQ-002 The block SHALL have parameter IDX_W, default 6 (= clog2(REGISTER_LENGTH)), which sets the width of a bit index.
REQ-003 clk_i  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 reset_i  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  request to load word_i and begin a scan.
REQ-006 word_i  input  REGISTER_LENGTH  word to be decomposed into set-bit indices.
REQ-007 busy_o  output  1  high while a scan is loaded and not yet complete (states SCAN and DONE).
REQ-008 idx_valid_o  output  1  idx_o holds a valid set-bit index.
REQ-009 idx_o  output  IDX_W  index of the lowest remaining set bit.
REQ-010 idx_ready_i  input  1  consumer accepts idx_o this cycle.
REQ-011 last_o  output  1  current idx_o is the final set bit of the word.
REQ-012 done_o  output  1  one-cycle pulse marking completion of a scan.
REQ-013 count_o  output  IDX_W+1  number of indices accepted in the current or most recent scan.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SCAN, DONE.
REQ-015 In IDLE, start_i=1 SHALL capture word_i into an internal pending register and clear count_o to 0.
- If word_i is nonzero, the FSM SHALL move to SCAN.
- If word_i is zero, the FSM SHALL move to DONE.
REQ-016 start_i SHALL be ignored in SCAN and DONE; the pending register SHALL NOT change because of it.
REQ-017 idx_valid_o SHALL be high in SCAN and only in SCAN; its first assertion SHALL be the cycle after start_i is sampled (latency 1).
REQ-018 idx_o SHALL equal the position of the least-significant 1 in the pending register; indices SHALL be emitted in strictly ascending order.
REQ-019 A transfer SHALL occur on any cycle where idx_valid_o=1 and idx_ready_i=1. On a transfer:
- the bit at idx_o SHALL be cleared in the pending register;
- count_o SHALL increment by 1.
REQ-020 While idx_valid_o=1 and idx_ready_i=0, idx_o, last_o and count_o SHALL hold stable.
REQ-021 last_o SHALL be high exactly when idx_valid_o=1 and the pending register has exactly one bit set.
REQ-022 A transfer with last_o=1 SHALL move the FSM to DONE on the next cycle.
REQ-023 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE unconditionally.
REQ-024 done_o SHALL be 0 in all states other than DONE.
REQ-025 count_o SHALL hold its final value through DONE and IDLE until the next accepted start_i.
REQ-026 An all-ones word SHALL produce REGISTER_LENGTH transfers, ending with idx_o = REGISTER_LENGTH-1, and count_o SHALL reach REGISTER_LENGTH without overflow.
REQ-027 With idx_ready_i held high, throughput SHALL be one index per cycle with no bubbles.
REQ-028 idx_ready_i SHALL be ignored outside SCAN.
REQ-029 When idx_valid_o=0, idx_o and last_o SHALL be driven to 0.

Reset
REQ-030 reset_i=1 at any clock edge SHALL force the following, overriding start_i and any pending transfer in that cycle:
- FSM to IDLE;
- pending register to 0;
- count_o to 0;
- busy_o, idx_valid_o, idx_o, last_o, done_o to 0.
REQ-031 Reset asserted mid-scan SHALL discard the remaining bits; no done_o pulse SHALL follow.
REQ-032 The first start_i SHALL be accepted on the first cycle after reset_i deasserts.

Verification
REQ-033 The bench SHALL cover a basic scan:
- Stimulus: word_i=64'h0000_0000_0000_0112, start_i pulse, idx_ready_i=1.
- Response: idx_o=1, 4, 8 on three consecutive cycles; last_o=1 only with 8; done_o the following cycle; count_o=3.
REQ-034 The bench SHALL cover a zero word:
- Stimulus: word_i=0, start_i pulse.
- Response: no idx_valid_o; done_o=1 on the next cycle; count_o=0; busy_o high for that one cycle.
REQ-035 The bench SHALL cover backpressure:
- Stimulus: word_i=64'h8000_0000_0000_0001, idx_ready_i=0 for 3 cycles, then 1.
- Response: idx_o=0 held stable for 4 cycles, then idx_o=63 with last_o=1; count_o=2.
REQ-036 The bench SHALL cover an all-ones word:
- Stimulus: word_i=64'hFFFF_FFFF_FFFF_FFFF, idx_ready_i=1.
- Response: 64 back-to-back indices 0..63; count_o=64; exactly one done_o pulse.
REQ-037 The bench SHALL cover start_i while busy:
- Stimulus: start_i with word_i=64'hF0 while scanning 64'h3.
- Response: outputs 0, 1 only; new word ignored.
REQ-038 The bench SHALL cover reset mid-scan:
- Stimulus: reset_i=1 after the first transfer of 64'h7.
- Response: next cycle idx_valid_o=0, busy_o=0, count_o=0; no done_o; a subsequent start_i with 64'h4 yields idx_o=2.
